// File: rtl/dmem_wait_responder.sv
// -----------------------------------------------------------------------------
// dmem_wait_responder
//
// Multi-cycle data-memory responder for the core's data port. One load/store
// is accepted at a time and completed after WAIT_CYCLES wait states with a
// single-cycle `ready` pulse, so the pipeline's memory-stall path can be
// exercised. Storage is an internal word array with per-byte write enables.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two)
//   AW           word-index width, log2(DEPTH)
//   WAIT_CYCLES  wait states before the response, 0..15
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   reset      in   asynchronous, active-low reset
//   req        in   request valid (only looked at while idle)
//   memwrite   in   1 = store, 0 = load
//   amp        in   byte-lane enables, bit i selects writedata[8i+7:8i]
//   addr       in   byte address, word index is addr[AW+1:2]
//   writedata  in   lane-aligned store data
//   readdata   out  full word read, valid with ready, held until next response
//   ready      out  one-cycle completion pulse
//   busy       out  request in flight (WAIT or RESP)
//   err        out  error pulse coincident with ready
//
// Build option
//   DMEM_ERR_EN  when defined, out-of-range or misaligned accesses raise `err`,
//                suppress the store and return zero. When undefined, addresses
//                wrap modulo 4*DEPTH and `err` is constant 0.
// -----------------------------------------------------------------------------
module dmem_wait_responder #(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memwrite,
  input  logic [3:0]  amp,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int CW = 4;  // wait counter width, covers 0..15

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;

  // Request captured at acceptance; later input changes are ignored.
  logic            wr_q;
  logic [3:0]      amp_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            err_q;

  // FSM-derived controls.
  logic            accept;
  logic            commit;
  logic            enter_resp;

  // Read side: the word is sampled on the edge that enters RESP. For
  // WAIT_CYCLES=0 that edge is the accepting edge, so the index and error
  // flag must come straight from the inputs rather than the captured copy.
  logic [AW-1:0]   rd_idx;
  logic            rd_err;
  logic [31:0]     rd_word;
  logic            acc_bad;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) here would make results depend on process
  // ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first; a path that leaves
  // it unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      // The counter was loaded with WAIT_CYCLES on entry, so leaving at 1
      // spends exactly WAIT_CYCLES cycles here.
      S_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and controls
  // ---------------------------------------------------------------------------
  always_comb begin
    ready  = 1'b0;
    busy   = 1'b0;
    accept = 1'b0;
    commit = 1'b0;
    unique case (state_q)
      S_IDLE: accept = req;
      S_WAIT: busy   = 1'b1;
      S_RESP: begin
        busy   = 1'b1;
        ready  = 1'b1;
        // The write lands on the edge leaving RESP, so a following load
        // (accepted no earlier than the next cycle) sees the new data.
        commit = wr_q & ~err_q;
      end
      default: ;
    endcase
  end

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
  assign rd_idx     = (state_q == S_IDLE) ? addr[AW+1:2] : idx_q;
  assign rd_err     = (state_q == S_IDLE) ? acc_bad      : err_q;

  // ---------------------------------------------------------------------------
  // Access checking
  // ---------------------------------------------------------------------------
`ifdef DMEM_ERR_EN
  always_comb begin
    acc_bad = (addr[31:AW+2] != '0);
    unique case (amp)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: ;
      4'b0011, 4'b1100: if (addr[0])            acc_bad = 1'b1;
      4'b1111:          if (addr[1:0] != 2'b00) acc_bad = 1'b1;
      default:                                  acc_bad = 1'b1;
    endcase
  end

  assign err = ready & err_q;
`else
  // Upper and byte-offset address bits are deliberately ignored: addresses
  // wrap modulo 4*DEPTH.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

  assign acc_bad = 1'b0;
  assign err     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Request capture and wait counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      amp_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q   <= CW'(WAIT_CYCLES);
        wr_q    <= memwrite;
        amp_q   <= amp;
        idx_q   <= addr[AW+1:2];
        wdata_q <= writedata;
        err_q   <= acc_bad;
      end else if (state_q == S_WAIT) begin
        cnt_q   <= cnt_q - CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: one byte plane per lane, each with its own write enable
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] plane [DEPTH];

    // NOTE: the storage array has no reset; clearing it would cost a clear
    // sequencer and prevent RAM inference. Contents are undefined until
    // written. An asserted reset forces IDLE, so an aborted store never
    // reaches this write.
    always_ff @(posedge clk) begin
      if (commit && amp_q[g]) begin
        plane[idx_q] <= wdata_q[8*g +: 8];
      end
    end

    assign rd_word[8*g +: 8] = plane[rd_idx];
  end

  // ---------------------------------------------------------------------------
  // Read data: captured on RESP entry (old word for stores), held until the
  // next response.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata <= '0;
    end else if (enter_resp) begin
      readdata <= rd_err ? '0 : rd_word;
    end
  end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_wait_responder
//
// Bench for dmem_wait_responder. Instance u_dut uses WAIT_CYCLES=2 and carries
// the table-driven vectors plus the reset-abort, wrap and error sequences;
// instance u_dut_z uses WAIT_CYCLES=0 for the held-request throughput case.
// -----------------------------------------------------------------------------
module tb_dmem_wait_responder;

  localparam int W0 = 2;
`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // WAIT_CYCLES=2 instance
  logic        req = 1'b0, memwrite = 1'b0;
  logic [3:0]  amp = '0;
  logic [31:0] addr = '0, writedata = '0;
  logic [31:0] readdata;
  logic        ready, busy, err;

  // WAIT_CYCLES=0 instance
  logic        req_z = 1'b0, memwrite_z = 1'b0;
  logic [3:0]  amp_z = '0;
  logic [31:0] addr_z = '0, writedata_z = '0;
  logic [31:0] readdata_z;
  logic        ready_z, busy_z, err_z;

  dmem_wait_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(W0)) u_dut (
    .clk(clk), .reset(reset), .req(req), .memwrite(memwrite), .amp(amp),
    .addr(addr), .writedata(writedata), .readdata(readdata),
    .ready(ready), .busy(busy), .err(err)
  );

  dmem_wait_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(0)) u_dut_z (
    .clk(clk), .reset(reset), .req(req_z), .memwrite(memwrite_z), .amp(amp_z),
    .addr(addr_z), .writedata(writedata_z), .readdata(readdata_z),
    .ready(ready_z), .busy(busy_z), .err(err_z)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Scoreboard entry: what the response must look like.
  typedef struct {
    logic [31:0] rd;
    logic        chk_rd;
    logic        err;
    string       name;
  } exp_t;

  exp_t sbq[$];

  // One transaction on u_dut. Entered and left one delta after a rising edge
  // with the DUT idle.
  task automatic xact(input logic we, input logic [3:0] m, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd,
                      input logic chk_rd, input logic exp_err, input string name);
    exp_t e;
    int   lat;
    logic seen;
    req = 1'b1; memwrite = we; amp = m; addr = a; writedata = wd;
    e.rd = exp_rd; e.chk_rd = chk_rd; e.err = exp_err; e.name = name;
    sbq.push_back(e);
    @(posedge clk); #1;
    // Scramble the inputs: the captured request must be unaffected.
    req = 1'b0; memwrite = ~we; amp = ~m; addr = ~a; writedata = ~wd;
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) check({name, "_busy"}, {31'd0, busy}, 32'd1);
      if (ready) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    e = sbq.pop_front();
    check({e.name, "_ready_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      check({e.name, "_latency"}, lat, W0 + 1);
      if (e.chk_rd) check({e.name, "_readdata"}, readdata, e.rd);
      check({e.name, "_err"}, {31'd0, err}, {31'd0, e.err});
    end
    @(posedge clk); #1;
    amp = '0; addr = '0; writedata = '0; memwrite = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  amp;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        chk;
    logic        err;
    string       name;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  task automatic run_table();
    vt[0]  = '{1'b1, 4'b1111, 32'h040, 32'h12345678, 32'h0,        1'b0, 1'b0, "st_40_full"};
    vt[1]  = '{1'b0, 4'b1111, 32'h040, 32'h0,        32'h12345678, 1'b1, 1'b0, "ld_40"};
    vt[2]  = '{1'b1, 4'b1111, 32'h080, 32'h00000000, 32'h0,        1'b0, 1'b0, "st_80_zero"};
    vt[3]  = '{1'b1, 4'b0010, 32'h080, 32'h0000AB00, 32'h00000000, 1'b1, 1'b0, "st_80_lane1"};
    vt[4]  = '{1'b1, 4'b1000, 32'h080, 32'hCD000000, 32'h0000AB00, 1'b1, 1'b0, "st_80_lane3"};
    vt[5]  = '{1'b0, 4'b1111, 32'h080, 32'h0,        32'hCD00AB00, 1'b1, 1'b0, "ld_80"};
    vt[6]  = '{1'b1, 4'b1111, 32'h084, 32'h01020304, 32'h0,        1'b0, 1'b0, "st_84_full"};
    vt[7]  = '{1'b1, 4'b1100, 32'h084, 32'hBEEF0000, 32'h01020304, 1'b1, 1'b0, "st_84_upper"};
    vt[8]  = '{1'b1, 4'b0001, 32'h084, 32'h000000EE, 32'hBEEF0304, 1'b1, 1'b0, "st_84_lane0"};
    vt[9]  = '{1'b0, 4'b1111, 32'h084, 32'h0,        32'hBEEF03EE, 1'b1, 1'b0, "ld_84"};
    vt[10] = '{1'b1, 4'b0000, 32'h040, 32'hFFFFFFFF,
               ERR_EN ? 32'h0 : 32'h12345678, 1'b1, ERR_EN, "st_40_noamp"};
    vt[11] = '{1'b0, 4'b1111, 32'h040, 32'h0,        32'h12345678, 1'b1, 1'b0, "ld_40_unchanged"};
    vt[12] = '{1'b1, 4'b1111, 32'hFFC, 32'h89ABCDEF, 32'h0,        1'b0, 1'b0, "st_top_word"};
    vt[13] = '{1'b0, 4'b1111, 32'hFFC, 32'h0,        32'h89ABCDEF, 1'b1, 1'b0, "ld_top_word"};
    for (int i = 0; i < NV; i++) begin
      xact(vt[i].we, vt[i].amp, vt[i].addr, vt[i].wd, vt[i].rd, vt[i].chk, vt[i].err, vt[i].name);
    end
    // readdata holds the last response while idle.
    repeat (3) @(posedge clk);
    #1;
    check("rd_hold_idle", readdata, 32'h89ABCDEF);
  endtask

  task automatic test_reset_mid_wait();
    xact(1'b1, 4'b1111, 32'h10, 32'h11111111, 32'h0, 1'b0, 1'b0, "preload_10");
    req = 1'b1; memwrite = 1'b1; amp = 4'b1111; addr = 32'h10; writedata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_busy",  {31'd0, busy},  32'd0);
    check("abort_rdata", readdata,       32'd0);
    check("abort_err",   {31'd0, err},   32'd0);
    @(posedge clk); #1;
    check("abort_busy_hold",  {31'd0, busy},  32'd0);
    check("abort_ready_hold", {31'd0, ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    xact(1'b0, 4'b1111, 32'h10, 32'h0, 32'h11111111, 1'b1, 1'b0, "ld_10_after_abort");
  endtask

  task automatic test_addr_map();
`ifdef DMEM_ERR_EN
    xact(1'b1, 4'b1111, 32'h0000, 32'h0BADF00D, 32'h0, 1'b0, 1'b0, "st_0_preload");
    xact(1'b1, 4'b1111, 32'h0002, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, "st_misaligned");
    xact(1'b0, 4'b1111, 32'h0000, 32'h0,        32'h0BADF00D, 1'b1, 1'b0, "ld_0_unchanged");
    xact(1'b0, 4'b1111, 32'h1004, 32'h0,        32'h0, 1'b1, 1'b1, "ld_out_of_range");
    xact(1'b0, 4'b0011, 32'h0001, 32'h0,        32'h0, 1'b1, 1'b1, "ld_half_odd");
`else
    xact(1'b1, 4'b1111, 32'h1004, 32'h00000055, 32'h0, 1'b0, 1'b0, "st_wrap_1004");
    xact(1'b0, 4'b1111, 32'h0004, 32'h0,        32'h00000055, 1'b1, 1'b0, "ld_wrap_0004");
    xact(1'b0, 4'b1111, 32'h0043, 32'h0,        32'h12345678, 1'b1, 1'b0, "ld_low_bits_ignored");
`endif
  endtask

  task automatic test_held_req();
    int pulses, first, last, gap_bad, low_run, max_low;
    pulses = 0; first = -1; last = -1; gap_bad = 0; low_run = 0; max_low = 0;
    req_z = 1'b1; memwrite_z = 1'b1; amp_z = 4'b1111; addr_z = 32'h200; writedata_z = 32'h77;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ready_z) begin
        if (first < 0) first = c;
        else if (c - last != 2) gap_bad++;
        last = c;
        pulses++;
      end
      if (first >= 0) begin
        if (!busy_z) low_run++;
        else low_run = 0;
        if (low_run > max_low) max_low = low_run;
      end
    end
    @(posedge clk); #1;
    req_z = 1'b0;
    check("held_pulses",     pulses,  4);
    check("held_first_lat",  first,   1);
    check("held_spacing",    gap_bad, 0);
    check("held_busy_gap",   {31'd0, max_low > 1}, 32'd0);
    // Single load on the zero-wait instance: ready in the next cycle.
    req_z = 1'b1; memwrite_z = 1'b0;
    @(posedge clk); #1;
    req_z = 1'b0;
    @(negedge clk);
    check("z_ld_ready", {31'd0, ready_z}, 32'd1);
    check("z_ld_rdata", readdata_z, 32'h77);
    check("z_ld_err",   {31'd0, err_z}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",   {31'd0, ready},   32'd0);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_err",     {31'd0, err},     32'd0);
    check("rst_rdata",   readdata,         32'd0);
    check("rst_z_ready", {31'd0, ready_z}, 32'd0);
    check("rst_z_busy",  {31'd0, busy_z},  32'd0);
    check("rst_z_rdata", readdata_z,       32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    test_reset_mid_wait();
    run_table();
    test_addr_map();
    test_held_req();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case anything above stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, expected finish before 200000");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/dmem_wait_responder.md
# dmem_wait_responder

Multi-cycle data-memory responder on the core's data port (`memwrite`, `amp`, `addr`, `writedata`, `readdata`). It accepts one load/store request at a time and completes it after a programmable number of wait states, driving a `ready` pulse so the pipeline can stall on memory. Storage is an internal word array with per-byte write enables. The block replaces the zero-latency data memory when stall handling in the pipelined core is exercised.

## Interface
- `DEPTH`, 1024: number of 32-bit words; power of two.
- `AW`, 10: word-index width, equal to log2(`DEPTH`).
- `WAIT_CYCLES`, 2: wait states inserted before the response; 0..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  request valid from the core.
- `memwrite`  in  1  1 = store, 0 = load; sampled with `req`.
- `amp`  in  4  byte-lane enables; bit i selects `writedata[8i+7:8i]`.
- `addr`  in  32  byte address; word index is `addr[AW+1:2]`.
- `writedata`  in  32  store data, already lane-aligned.
- `readdata`  out  32  full word read; valid while `ready`=1, held until the next response.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  1 while a request is in flight (WAIT or RESP).
- `err`  out  1  error pulse coincident with `ready`; only present with `DMEM_ERR_EN`, otherwise tied 0.

## Operation
- FSM states and transitions:
  - IDLE: `req`=1 accepts the request. Latch `memwrite`, `amp`, word index, and `writedata`. Load the wait counter with `WAIT_CYCLES`. Go to WAIT, or to RESP if `WAIT_CYCLES`=0.
  - WAIT: decrement the counter each cycle. Go to RESP when the counter reaches 1.
  - RESP: perform the access and assert `ready` for exactly this cycle. Return to IDLE.
- Load: `readdata` is registered from `mem[idx]` at the RESP entry edge. The core performs byte/half extraction and extension.
- Store: write only the lanes with `amp[i]`=1, on the edge leaving RESP. `amp`=0000 leaves memory unchanged. A store response drives `readdata` with the old word.
- Inputs are ignored outside IDLE. Changes to `addr`, `writedata`, or `amp` mid-transaction have no effect.
- Back-to-back requests: the earliest next acceptance is the cycle after `ready`. If `req` is still high in that IDLE cycle, it is a new request. The initiator must drop `req` or present the next request there.
- Address bits above `AW+1` are ignored, so addresses wrap modulo 4*`DEPTH`. Bits [1:0] are ignored.
- Memory contents are not reset. They are undefined until written, or until preloaded by the bench via hierarchical `$readmemh`.

## Timing
- Reset values: state IDLE, `ready`=0, `busy`=0, `err`=0, `readdata`=0, counter=0.
- Latency is `WAIT_CYCLES`+1 cycles from the accepting edge to the `ready` cycle.
  - `WAIT_CYCLES`=0: `ready` is high in the cycle after acceptance.
  - Default of 2: `ready` is high in the third cycle.
- Throughput is one request per `WAIT_CYCLES`+2 cycles with back-to-back `req`.
- `busy` rises on the accepting edge and falls on the edge leaving RESP.
- Reset asserted mid-transaction aborts it at once: no memory write, no `ready`, FSM returns to IDLE.
- A store followed by a load to the same word returns the new data. The write commits before the next acceptance.

## Configuration
- `DMEM_ERR_EN` defined:
  - If the address is out of range (`addr[31:AW+2]`≠0) or misaligned for `amp`, `err` pulses with `ready`, the store is suppressed, and `readdata` is 0.
  - Misaligned means: 1111 with `addr[1:0]`≠00, 0011/1100 with `addr[0]`=1, or any `amp` pattern not in {0001, 0010, 0100, 1000, 0011, 1100, 1111}.
- `DMEM_ERR_EN` undefined: no checking, addresses wrap, and `err` is constant 0.

## Test plan
- Reset mid-WAIT: with `WAIT_CYCLES`=2, accept a store of 0xDEADBEEF to 0x10 with `amp`=1111, then pull `reset` low before `ready`. A later load of 0x10 must return the preloaded value, and `ready`, `busy`, and `readdata` must all be 0 during reset.
- Full-word store then load: store 0x12345678 to 0x40 with `amp`=1111, then load 0x40. Each `ready` must come exactly 3 cycles after acceptance, and the load must return 0x12345678.
- Byte-lane stores: preload 0x00000000 at 0x80. Store 0x0000AB00 with `amp`=0010, then 0xCD000000 with `amp`=1000. A load must return 0xCD00AB00.
- Held `req` back-to-back: hold `req` high for 8 cycles with `WAIT_CYCLES`=0. This must give 4 `ready` pulses, 2 cycles apart, and `busy` must never be low for more than one cycle between them.
- Wrap: with `DEPTH`=1024 and `DMEM_ERR_EN` off, store 0x55 to 0x1004. A load of 0x0004 must return 0x55, with `err`=0.
- Error: with `DMEM_ERR_EN` on, store 0xFFFFFFFF to 0x0002 with `amp`=1111. `err` and `ready` must pulse together, and a subsequent load of 0x0000 must return the unchanged word.
